vc_assoc_controller: RTL

VC_ASSOC_CONTROLLER -- requirements
Module: vc_assoc_controller

---
 rtl/vc_assoc_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vc_assoc_controller.sv
// vc_assoc_controller: fully-associative victim cache controller (lookup, swap, LRU insert, dirty writeback); optional VC_PERF_CNT_EN counters; ports clk_i/rst_i, lkp_*, evict_*, busy_o, res_*, hit_o, wb_*, no_acc_o/no_hit_o/no_miss_o
module vc_assoc_controller #(
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lkp_valid_i,
  input  logic [ADDR_W-1:0] lkp_addr_i,
  input  logic              evict_valid_i,
  input  logic [ADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0] evict_data_i,
  input  logic              evict_dirty_i,
  output logic              busy_o,
  output logic              res_valid_o,
  output logic              hit_o,
  output logic [LINE_W-1:0] res_data_o,
  output logic              res_dirty_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [LINE_W-1:0] wb_data_o,
  output logic [31:0]       no_acc_o,
  output logic [31:0]       no_hit_o,
  output logic [31:0]       no_miss_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - OFFSET_W;
  typedef enum logic [1:0] {IDLE, COMPARE, INSERT, WRITEBACK} state_e;
  state_e state_q;
  logic [ENTRIES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [LINE_W-1:0] data_q [ENTRIES];
  logic [IDX_W-1:0] age_q [ENTRIES];
  logic [IDX_W-1:0] age_d [ENTRIES];
  logic ev_valid_q, ev_dirty_q;
  logic [TAG_W-1:0] ev_tag_q;
  logic [LINE_W-1:0] ev_data_q;
  logic busy_q, res_valid_q, hit_q, res_dirty_q, wb_valid_q;
  logic [LINE_W-1:0] res_data_q, wb_data_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [IDX_W-1:0] hidx_q, wb_slot_q;
  logic l_hit, m_hit, inv_any, need_wb, wr_en;
  logic [IDX_W-1:0] l_idx, m_idx, inv_idx, lru_idx, slot, t_idx;
  logic unused_ok;
  assign unused_ok = ^{lkp_addr_i[OFFSET_W-1:0], evict_addr_i[OFFSET_W-1:0]};
  // Lookup compares against the live address in IDLE; entries cannot change before COMPARE
  always_comb begin
    l_hit = 1'b0;
    l_idx = '0;
    m_hit = 1'b0;
    m_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    lru_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == lkp_addr_i[ADDR_W-1:OFFSET_W]) begin
        l_hit = 1'b1;
        l_idx = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == ev_tag_q) begin
        m_hit = 1'b1;
        m_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_idx = IDX_W'(i);
      end
      if (age_q[i] == IDX_W'(ENTRIES - 1)) lru_idx = IDX_W'(i);
    end
    // Same-tag entry first (no duplicates), then lowest invalid, then LRU
    slot = m_hit ? m_idx : inv_any ? inv_idx : lru_idx;
    need_wb = !m_hit && !inv_any && dirty_q[lru_idx];
    t_idx = state_q == COMPARE ? hidx_q : state_q == WRITEBACK ? wb_slot_q : slot;
    wr_en = (state_q == COMPARE && hit_q && ev_valid_q) || (state_q == INSERT && !need_wb) ||
            (state_q == WRITEBACK && wb_ready_i);
    // Ages stay a permutation of 0..ENTRIES-1: touched entry -> 0, younger ones age by one
    for (int i = 0; i < ENTRIES; i++)
      age_d[i] = IDX_W'(i) == t_idx ? '0 : age_q[i] < age_q[t_idx] ? age_q[i] + 1'b1 : age_q[i];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      res_valid_q <= 1'b0;
      hit_q <= 1'b0;
      res_data_q <= '0;
      res_dirty_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_slot_q <= '0;
      hidx_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      ev_valid_q <= 1'b0;
      ev_dirty_q <= 1'b0;
      ev_tag_q <= '0;
      ev_data_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        age_q[i] <= IDX_W'(i);
        tag_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (lkp_valid_i || evict_valid_i) begin
          ev_valid_q <= evict_valid_i;
          ev_tag_q <= evict_addr_i[ADDR_W-1:OFFSET_W];
          ev_data_q <= evict_data_i;
          ev_dirty_q <= evict_dirty_i;
          busy_q <= 1'b1;
          state_q <= lkp_valid_i ? COMPARE : INSERT;
          if (lkp_valid_i) begin
            res_valid_q <= 1'b1;
            hit_q <= l_hit;
            hidx_q <= l_idx;
            res_data_q <= l_hit ? data_q[l_idx] : '0;
            res_dirty_q <= l_hit && dirty_q[l_idx];
          end
        end
        COMPARE: begin
          if (hit_q && !ev_valid_q) valid_q[hidx_q] <= 1'b0;
          state_q <= !hit_q && ev_valid_q ? INSERT : IDLE;
          busy_q <= !hit_q && ev_valid_q;
        end
        INSERT: if (need_wb) begin
          state_q <= WRITEBACK;
          wb_valid_q <= 1'b1;
          wb_addr_q <= {tag_q[slot], {OFFSET_W{1'b0}}};
          wb_data_q <= data_q[slot];
          wb_slot_q <= slot;
        end else begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: if (wb_ready_i) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          wb_valid_q <= 1'b0;
        end
      endcase
      if (wr_en) begin
        valid_q[t_idx] <= 1'b1;
        dirty_q[t_idx] <= ev_dirty_q;
        tag_q[t_idx] <= ev_tag_q;
        data_q[t_idx] <= ev_data_q;
        age_q <= age_d;
      end
    end
  end
  assign busy_o = busy_q;
  assign res_valid_o = res_valid_q;
  assign hit_o = hit_q;
  assign res_data_o = res_data_q;
  assign res_dirty_o = res_dirty_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
`ifdef VC_PERF_CNT_EN
  logic [31:0] acc_q, miss_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      miss_q <= '0;
    end else begin
      if (state_q == IDLE && lkp_valid_i) acc_q <= acc_q + 32'd1;
      if (state_q == COMPARE && !hit_q) miss_q <= miss_q + 32'd1;
    end
  end
  assign no_acc_o = acc_q;
  assign no_miss_o = miss_q;
  assign no_hit_o = acc_q - miss_q;
`else
  assign no_acc_o = '0;
  assign no_miss_o = '0;
  assign no_hit_o = '0;
`endif
endmodule
